// File: rtl/mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mem_burst_ctrl
//
// Main-memory side of the cache refill/writeback path. Accepts one block-aligned
// read (refill) or write (writeback) command at a time. Each command waits a fixed
// number of cycles, then moves a BURST_LEN-beat block one beat per cycle, then
// signals completion. The backing byte array lives here. It has no reset so it
// can map onto block RAM.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous, active-low reset
//   readMem   in   read (refill) command request, sampled only while idle
//   writeMem  in   write (writeback) command request, sampled only while idle
//   adrMM     in   block address; offset bits are forced to 0, bits at and above
//                  MEM_ADR_WIDTH are dropped
//   wdataMM   in   write beat data for beat wbeatMM, captured at the end of the cycle
//   readyMem  out  high while idle; a request is accepted on an edge while high
//   rdataMM   out  read beat data
//   rvalidMM  out  rdataMM holds a beat this cycle
//   wbeatMM   out  index of the write beat captured this cycle
//   wactMM    out  wdataMM is captured at the end of this cycle
//   doneMM    out  one-cycle completion pulse
//   errMM     out  one-cycle pulse when readMem and writeMem arrive together
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_burst_ctrl #(
   parameter int unsigned ADR_WIDTH     = 16,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned MEM_ADR_WIDTH = 12,
   parameter int unsigned BURST_LEN     = 4,
   parameter int unsigned LATENCY       = 3,
   parameter string       INIT_FILE     = "",
   localparam int unsigned BeatW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  readMem,
   input  logic                  writeMem,
   input  logic [ADR_WIDTH-1:0]  adrMM,
   input  logic [DATA_WIDTH-1:0] wdataMM,
   output logic                  readyMem,
   output logic [DATA_WIDTH-1:0] rdataMM,
   output logic                  rvalidMM,
   output logic [BeatW-1:0]      wbeatMM,
   output logic                  wactMM,
   output logic                  doneMM,
   output logic                  errMM
);

   localparam int unsigned LatW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam int unsigned Depth = 2 ** MEM_ADR_WIDTH;
   // Offset bits of an address inside one block.
   localparam logic [MEM_ADR_WIDTH-1:0] OffMask = MEM_ADR_WIDTH'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLat,
      StRburst,
      StWburst,
      StDone
   } state_t;

   // Control state.
   state_t                   r_state, w_state_d;
   logic [MEM_ADR_WIDTH-1:0] r_base, w_base_d;
   logic [BeatW-1:0]         r_beat, w_beat_d;
   logic [LatW-1:0]          r_lat, w_lat_d;
   logic                     r_rd, w_rd_d;
   logic                     w_err_d;

   // Output flops.
   logic                     r_ready;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic                     r_rvalid;
   logic [BeatW-1:0]         r_wbeat;
   logic                     r_wact;
   logic                     r_done;
   logic                     r_err;

   // Backing array.
   logic [DATA_WIDTH-1:0]    r_mem [Depth];
   logic [MEM_ADR_WIDTH-1:0] w_raddr;
   logic [MEM_ADR_WIDTH-1:0] w_waddr;
   logic [MEM_ADR_WIDTH-1:0] w_cmd_base;

   // Address bits above the array are discarded, so addresses wrap.
   if (ADR_WIDTH > MEM_ADR_WIDTH) begin : g_unused_adr
      logic w_unused_adr;
      assign w_unused_adr = ^adrMM[ADR_WIDTH-1:MEM_ADR_WIDTH];
   end

   assign w_cmd_base = adrMM[MEM_ADR_WIDTH-1:0] & ~OffMask;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_d = r_state;
      w_base_d  = r_base;
      w_beat_d  = r_beat;
      w_lat_d   = r_lat;
      w_rd_d    = r_rd;
      w_err_d   = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (readMem || writeMem) begin
               w_base_d = w_cmd_base;
               // If both requests are high, the read is performed.
               w_rd_d   = readMem;
               w_err_d  = readMem && writeMem;
               w_beat_d = '0;
               if (LATENCY > 0) begin
                  w_state_d = StLat;
                  w_lat_d   = LatW'(LATENCY);
               end else begin
                  w_state_d = readMem ? StRburst : StWburst;
               end
            end
         end
         StLat: begin
            w_lat_d = r_lat - LatW'(1);
            if (r_lat == LatW'(1)) begin
               w_state_d = r_rd ? StRburst : StWburst;
            end
         end
         StRburst, StWburst: begin
            // The block is aligned, so the beat index never carries into r_base.
            w_beat_d = r_beat + BeatW'(1);
            if (r_beat == BeatW'(BURST_LEN - 1)) begin
               w_state_d = StDone;
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control registers and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= StIdle;
         r_base   <= '0;
         r_beat   <= '0;
         r_lat    <= '0;
         r_rd     <= 1'b0;
         r_ready  <= 1'b1;
         r_rvalid <= 1'b0;
         r_wbeat  <= '0;
         r_wact   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_base   <= w_base_d;
         r_beat   <= w_beat_d;
         r_lat    <= w_lat_d;
         r_rd     <= w_rd_d;
         // Outputs are decoded from the next state so they line up with it.
         r_ready  <= (w_state_d == StIdle);
         r_rvalid <= (w_state_d == StRburst);
         r_wact   <= (w_state_d == StWburst);
         r_wbeat  <= (w_state_d == StWburst) ? w_beat_d : '0;
         r_done   <= (w_state_d == StDone);
         r_err    <= w_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Backing array
   // ---------------------------------------------------------------------------
   // The read address comes from the next-state beat. The array read then lands in
   // r_rdata in the same cycle that rvalidMM rises.
   assign w_raddr = w_base_d | (MEM_ADR_WIDTH'(w_beat_d) & OffMask);
   assign w_waddr = r_base | (MEM_ADR_WIDTH'(r_wbeat) & OffMask);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rdata <= '0;
      end else if (w_state_d == StRburst) begin
         r_rdata <= r_mem[w_raddr];
      end else begin
         r_rdata <= '0;
      end
   end

   // No reset here. A reset in the middle of a burst keeps the beats already
   // written, and r_wact is cleared by the reset, so no further beat is written.
   always_ff @(posedge CLK) begin
      if (r_wact) begin
         r_mem[w_waddr] <= wdataMM;
      end
   end

   assign readyMem = r_ready;
   assign rdataMM  = r_rdata;
   assign rvalidMM = r_rvalid;
   assign wbeatMM  = r_wbeat;
   assign wactMM   = r_wact;
   assign doneMM   = r_done;
   assign errMM    = r_err;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_ctrl
//
// Two instances are driven: inst0 has LATENCY=3 and inst1 has LATENCY=0. Both
// use BURST_LEN=4 and MEM_ADR_WIDTH=12. For each instance the model records the
// acceptance edge of the current command. It derives every output from the
// cycle offset to that edge and from a byte array that mirrors the writes. A
// negedge process compares all outputs with the model on every cycle. The
// directed tests also compare logged events with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_mem_burst_ctrl;

   logic            CLK;
   logic            RST;
   logic [1:0]      rd, wr;
   logic [1:0][15:0] adr;
   logic [1:0][7:0] wdata, rdata;
   logic [1:0][1:0] wbeat;
   logic [1:0]      ready, rvalid, wact, done, err;
   logic [7:0]      wpat [2][4];

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;

   // Cache side: present the block byte for the requested write beat.
   assign wdata[0] = wpat[0][wbeat[0]];
   assign wdata[1] = wpat[1][wbeat[1]];

   mem_burst_ctrl #(.LATENCY(3)) u_dut0 (
      .CLK(CLK), .RST(RST), .readMem(rd[0]), .writeMem(wr[0]), .adrMM(adr[0]),
      .wdataMM(wdata[0]), .readyMem(ready[0]), .rdataMM(rdata[0]), .rvalidMM(rvalid[0]),
      .wbeatMM(wbeat[0]), .wactMM(wact[0]), .doneMM(done[0]), .errMM(err[0])
   );

   mem_burst_ctrl #(.LATENCY(0)) u_dut1 (
      .CLK(CLK), .RST(RST), .readMem(rd[1]), .writeMem(wr[1]), .adrMM(adr[1]),
      .wdataMM(wdata[1]), .readyMem(ready[1]), .rdataMM(rdata[1]), .rvalidMM(rvalid[1]),
      .wbeatMM(wbeat[1]), .wactMM(wact[1]), .doneMM(done[1]), .errMM(err[1])
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp,
                  $time);
      end
   endtask

   function automatic int lat_of(input int i);
      return (i == 0) ? 3 : 0;
   endfunction

   // ---------------------------------------------------------------------------
   // Model. Period p ends at edge p. Beat k of a command accepted at edge n falls
   // in period n+L+1+k, done in n+L+5, and the block is idle again from n+L+6.
   // ---------------------------------------------------------------------------
   bit        act   [2];
   int        acc   [2];
   bit        is_rd [2];
   bit        both  [2];
   int        base  [2];
   logic [7:0] mm   [2][4096];
   bit        kn    [2][4096];

   always @(posedge CLK) begin
      edge_cnt <= edge_cnt + 1;
      if (RST) begin
         for (int i = 0; i < 2; i++) begin
            automatic int e = edge_cnt + 1;
            automatic int o = e - acc[i];
            automatic int k = o - lat_of(i) - 1;
            if (act[i] && !is_rd[i] && k >= 0 && k < 4) begin
               mm[i][base[i] + k] <= wdata[i];
               kn[i][base[i] + k] <= 1'b1;
            end
            if ((!act[i] || o >= lat_of(i) + 6) && (rd[i] || wr[i])) begin
               act[i]   <= 1'b1;
               acc[i]   <= e;
               is_rd[i] <= rd[i];
               both[i]  <= rd[i] && wr[i];
               base[i]  <= int'(adr[i]) & 32'h0FFC;
            end
         end
      end
   end

   always @(negedge RST) begin
      act[0] <= 1'b0;
      act[1] <= 1'b0;
   end

   // Event logs for the instance under directed test.
   int mon = 0;
   int rv_per[$];
   int rv_dat[$];
   int wa_per[$];
   int wa_beat[$];
   int dn_per[$];
   int er_n;

   function automatic int qget(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   task automatic clear_mon(input int i);
      mon = i;
      rv_per.delete();
      rv_dat.delete();
      wa_per.delete();
      wa_beat.delete();
      dn_per.delete();
      er_n = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Cycle-by-cycle compare against the model
   // ---------------------------------------------------------------------------
   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         automatic int p      = edge_cnt + 1;
         automatic int l      = lat_of(i);
         automatic int o      = p - acc[i];
         automatic int k      = o - l - 1;
         automatic bit live   = RST && act[i] && (o < l + 6);
         automatic bit e_beat = live && k >= 0 && k < 4;
         automatic bit e_rv   = e_beat && is_rd[i];
         automatic bit e_wa   = e_beat && !is_rd[i];
         chk($sformatf("i%0d_ready", i), int'(ready[i]), int'(!live));
         chk($sformatf("i%0d_rvalid", i), int'(rvalid[i]), int'(e_rv));
         chk($sformatf("i%0d_wact", i), int'(wact[i]), int'(e_wa));
         chk($sformatf("i%0d_done", i), int'(done[i]), int'(live && o == l + 5));
         chk($sformatf("i%0d_err", i), int'(err[i]), int'(live && o == 1 && both[i]));
         if (e_wa) chk($sformatf("i%0d_wbeat", i), int'(wbeat[i]), k);
         if (e_rv && kn[i][base[i] + k]) begin
            chk($sformatf("i%0d_rdata", i), int'(rdata[i]), int'(mm[i][base[i] + k]));
         end
         if (!RST) begin
            chk($sformatf("i%0d_rst_rdata", i), int'(rdata[i]), 0);
            chk($sformatf("i%0d_rst_wbeat", i), int'(wbeat[i]), 0);
         end
      end
      if (RST) begin
         if (rvalid[mon]) begin
            rv_per.push_back(edge_cnt + 1);
            rv_dat.push_back(int'(rdata[mon]));
         end
         if (wact[mon]) begin
            wa_per.push_back(edge_cnt + 1);
            wa_beat.push_back(int'(wbeat[mon]));
         end
         if (done[mon]) dn_per.push_back(edge_cnt + 1);
         if (err[mon]) er_n++;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic set_pat(input int i, input logic [31:0] p);
      wpat[i][0] = p[31:24];
      wpat[i][1] = p[23:16];
      wpat[i][2] = p[15:8];
      wpat[i][3] = p[7:0];
   endtask

   // Present a request for one cycle. n is the edge that samples it.
   task automatic go(input int i, input bit r, input bit w, input logic [15:0] a, output int n);
      @(negedge CLK);
      rd[i]  = r;
      wr[i]  = w;
      adr[i] = a;
      n      = edge_cnt + 1;
      @(negedge CLK);
      rd[i] = 1'b0;
      wr[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int c = 0;
      while (done[i] !== 1'b1 && c < 40) begin
         @(negedge CLK);
         c++;
      end
      chk($sformatf("i%0d_done_seen", i), int'(done[i] === 1'b1), 1);
      repeat (3) @(negedge CLK);
   endtask

   task automatic run(input int i, input bit r, input bit w, input logic [15:0] a, output int n);
      clear_mon(i);
      go(i, r, w, a, n);
      wait_done(i);
   endtask

   task automatic chk_rd4(input string nm, input logic [31:0] p);
      chk({nm, "_cnt"}, rv_dat.size(), 4);
      chk({nm, "_b0"}, qget(rv_dat, 0), int'(p[31:24]));
      chk({nm, "_b1"}, qget(rv_dat, 1), int'(p[23:16]));
      chk({nm, "_b2"}, qget(rv_dat, 2), int'(p[15:8]));
      chk({nm, "_b3"}, qget(rv_dat, 3), int'(p[7:0]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      RST = 1'b1;
      rd  = '0;
      wr  = '0;
      adr = '0;
      set_pat(0, 32'h0);
      set_pat(1, 32'h0);
      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_ready", int'(ready[0]), 1);
      chk("rst_rvalid", int'(rvalid[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      // Write the refill block 0x40 with 11,22,33,44.
      set_pat(0, 32'h11223344);
      run(0, 1'b0, 1'b1, 16'h0040, n);

      // Writeback to 0x0100: beats in N+4..N+7, done in N+8.
      set_pat(0, 32'hA0A1A2A3);
      run(0, 1'b0, 1'b1, 16'h0100, n);
      chk("wb_cnt", wa_per.size(), 4);
      chk("wb_first", qget(wa_per, 0) - n, 4);
      chk("wb_last", qget(wa_per, 3) - n, 7);
      chk("wb_beat0", qget(wa_beat, 0), 0);
      chk("wb_beat3", qget(wa_beat, 3), 3);
      chk("wb_done", qget(dn_per, 0) - n, 8);

      // Read back 0x0100.
      run(0, 1'b1, 1'b0, 16'h0100, n);
      chk_rd4("rb100", 32'hA0A1A2A3);
      chk("rb100_first", qget(rv_per, 0) - n, 4);
      chk("rb100_done", qget(dn_per, 0) - n, 8);

      // Refill at 0x0042 reads the aligned block 0x40.
      run(0, 1'b1, 1'b0, 16'h0042, n);
      chk_rd4("rf42", 32'h11223344);
      chk("rf42_first", qget(rv_per, 0) - n, 4);

      // Reset during beat 2 of a read.
      clear_mon(0);
      go(0, 1'b1, 1'b0, 16'h0040, n);
      repeat (4) @(negedge CLK);
      @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("arst_rvalid", int'(rvalid[0]), 0);
      chk("arst_ready", int'(ready[0]), 1);
      chk("arst_done", int'(done[0]), 0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("arst_beats", rv_dat.size(), 2);
      chk("arst_b1", qget(rv_dat, 1), 32'h22);
      chk("arst_dn", dn_per.size(), 0);
      run(0, 1'b1, 1'b0, 16'h0040, n);
      chk_rd4("arst_reread", 32'h11223344);

      // Simultaneous read and write: error pulse, a read is performed, no write.
      set_pat(0, 32'h5A5B5C5D);
      run(0, 1'b0, 1'b1, 16'h0200, n);
      set_pat(0, 32'hEEEEEEEE);
      run(0, 1'b1, 1'b1, 16'h0200, n);
      chk("both_err", er_n, 1);
      chk("both_wact", wa_per.size(), 0);
      chk_rd4("both_rd", 32'h5A5B5C5D);
      run(0, 1'b1, 1'b0, 16'h0200, n);
      chk_rd4("both_after", 32'h5A5B5C5D);

      // 0xF004 wraps to array index 0x004.
      set_pat(0, 32'hC0C1C2C3);
      run(0, 1'b0, 1'b1, 16'hF004, n);
      run(0, 1'b1, 1'b0, 16'h0004, n);
      chk_rd4("wrap", 32'hC0C1C2C3);

      // A write request during the latency wait is ignored.
      set_pat(0, 32'h99999999);
      clear_mon(0);
      go(0, 1'b1, 1'b0, 16'h0004, n);
      @(negedge CLK);
      wr[0] = 1'b1;
      @(negedge CLK);
      wr[0] = 1'b0;
      repeat (14) @(negedge CLK);
      chk("ign_done_cnt", dn_per.size(), 1);
      chk("ign_done", qget(dn_per, 0) - n, 8);
      chk("ign_wact", wa_per.size(), 0);
      chk_rd4("ign_rd", 32'hC0C1C2C3);

      // LATENCY=0: write, then reads held back to back.
      set_pat(1, 32'h71727374);
      run(1, 1'b0, 1'b1, 16'h0300, n);
      chk("l0_wb_first", qget(wa_per, 0) - n, 1);
      chk("l0_wb_done", qget(dn_per, 0) - n, 5);
      clear_mon(1);
      @(negedge CLK);
      rd[1]  = 1'b1;
      adr[1] = 16'h0300;
      n      = edge_cnt + 1;
      repeat (7) @(negedge CLK);
      rd[1] = 1'b0;
      repeat (10) @(negedge CLK);
      chk("b2b_done_cnt", dn_per.size(), 2);
      chk("b2b_done0", qget(dn_per, 0) - n, 5);
      chk("b2b_done1", qget(dn_per, 1) - n, 11);
      chk("b2b_rv_cnt", rv_per.size(), 8);
      chk("b2b_rv0", qget(rv_per, 0) - n, 1);
      chk("b2b_rv4", qget(rv_per, 4) - n, 7);
      chk("b2b_d5", qget(rv_dat, 5), 32'h72);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
